// File: rtl/kf_frame_ctrl.sv
// Frame controller for top_kf: accepts one sample per frame, launches the filter,
// waits for done with a timeout, and commits the posterior as next state and published estimate.
module kf_frame_ctrl #(
  parameter int              N        = 20,
  parameter int              FRAC     = 10,
  parameter int              TIMEOUT  = 38,
  parameter logic [N-1:0]    X00_INIT = '0,
  parameter logic [N-1:0]    X10_INIT = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     s_u00,
  input  logic [N-1:0]     s_u10,
  input  logic [N-1:0]     s_z00,
  input  logic [N-1:0]     s_z10,
  input  logic             clear_state,
  output logic             kf_start,
  input  logic             kf_done,
  output logic [N-1:0]     kf_u00,
  output logic [N-1:0]     kf_u10,
  output logic [N-1:0]     kf_z00,
  output logic [N-1:0]     kf_z10,
  output logic [N-1:0]     kf_x00_prev,
  output logic [N-1:0]     kf_x10_prev,
  input  logic [N-1:0]     kf_X00_post,
  input  logic [N-1:0]     kf_X10_post,
  output logic             m_valid,
  output logic [N-1:0]     m_x00,
  output logic [N-1:0]     m_x10,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             timeout_err
);

  // FRAC only documents the fixed-point format; it is folded into a zero term so it stays referenced.
  localparam int          WCNT_W = 8 + (FRAC - FRAC);
  localparam logic [WCNT_W-1:0] TMO = WCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_COMMIT} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              start_q, start_d;
  logic              mval_q, mval_d;
  logic              terr_q, terr_d;
  logic              pend_q, pend_d;
  logic              pend_eff;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      u00_q, u00_d, u10_q, u10_d, z00_q, z00_d, z10_q, z10_d;
  logic [N-1:0]      xp0_q, xp0_d, xp1_q, xp1_d;
  logic [N-1:0]      mx0_q, mx0_d, mx1_q, mx1_d;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    start_d  = 1'b0;
    mval_d   = 1'b0;
    terr_d   = terr_q;
    pend_d   = pend_q;
    pend_eff = pend_q | clear_state;
    cnt_d    = cnt_q;
    u00_d    = u00_q;
    u10_d    = u10_q;
    z00_d    = z00_q;
    z10_d    = z10_q;
    xp0_d    = xp0_q;
    xp1_d    = xp1_q;
    mx0_d    = mx0_q;
    mx1_d    = mx1_q;

    unique case (state_q)
      ST_IDLE: begin
        // Reload happens at the accept edge too, so the launched frame already sees INIT.
        if (pend_eff) begin
          xp0_d  = X00_INIT;
          xp1_d  = X10_INIT;
          pend_d = 1'b0;
        end
        if (s_valid) begin
          u00_d   = s_u00;
          u10_d   = s_u10;
          z00_d   = s_z00;
          z10_d   = s_z10;
          start_d = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wcnt_d  = WCNT_W'(1);
        pend_d  = pend_eff;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (kf_done) begin
          mx0_d   = kf_X00_post;
          mx1_d   = kf_X10_post;
          xp0_d   = pend_eff ? X00_INIT : kf_X00_post;
          xp1_d   = pend_eff ? X10_INIT : kf_X10_post;
          pend_d  = 1'b0;
          mval_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_COMMIT;
        end else if (wcnt_q == TMO) begin
          if (pend_eff) begin
            xp0_d = X00_INIT;
            xp1_d = X10_INIT;
          end
          pend_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          pend_d = pend_eff;
        end
      end
      ST_COMMIT: begin
        pend_d  = pend_eff;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      start_q <= 1'b0;
      mval_q  <= 1'b0;
      terr_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      u00_q   <= '0;
      u10_q   <= '0;
      z00_q   <= '0;
      z10_q   <= '0;
      xp0_q   <= X00_INIT;
      xp1_q   <= X10_INIT;
      mx0_q   <= '0;
      mx1_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      start_q <= start_d;
      mval_q  <= mval_d;
      terr_q  <= terr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      u00_q   <= u00_d;
      u10_q   <= u10_d;
      z00_q   <= z00_d;
      z10_q   <= z10_d;
      xp0_q   <= xp0_d;
      xp1_q   <= xp1_d;
      mx0_q   <= mx0_d;
      mx1_q   <= mx1_d;
    end
  end

  assign s_ready     = (state_q == ST_IDLE);
  assign kf_start    = start_q;
  assign kf_u00      = u00_q;
  assign kf_u10      = u10_q;
  assign kf_z00      = z00_q;
  assign kf_z10      = z10_q;
  assign kf_x00_prev = xp0_q;
  assign kf_x10_prev = xp1_q;
  assign m_valid     = mval_q;
  assign m_x00       = mx0_q;
  assign m_x10       = mx1_q;
  assign frame_cnt   = cnt_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_kf_frame_ctrl.sv
// Directed bench for kf_frame_ctrl: frame handshake, timeout, state clear, done filtering,
// counter wrap and mid-frame reset, each checked against hand-computed values.
module tb_kf_frame_ctrl;
  localparam int N = 20;
  localparam int TMO = 38;
  localparam int CW = 4;
  localparam logic [N-1:0] XI0 = 20'h00123;
  localparam logic [N-1:0] XI1 = 20'hFFEDD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, s_ready;
  logic [N-1:0] s_u00 = '0, s_u10 = '0, s_z00 = '0, s_z10 = '0;
  logic clear_state = 1'b0;
  logic kf_start, kf_done = 1'b0;
  logic [N-1:0] kf_u00, kf_u10, kf_z00, kf_z10, kf_x00_prev, kf_x10_prev;
  logic [N-1:0] kf_X00_post = '0, kf_X10_post = '0;
  logic m_valid;
  logic [N-1:0] m_x00, m_x10;
  logic [CW-1:0] frame_cnt;
  logic timeout_err;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int mv_cnt = 0;

  logic [N-1:0] ex0, ex1;
  logic [CW-1:0] ecnt;
  bit eterr;

  kf_frame_ctrl #(
    .N(N), .FRAC(10), .TIMEOUT(TMO), .X00_INIT(XI0), .X10_INIT(XI1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_u00(s_u00), .s_u10(s_u10), .s_z00(s_z00), .s_z10(s_z10),
    .clear_state(clear_state),
    .kf_start(kf_start), .kf_done(kf_done),
    .kf_u00(kf_u00), .kf_u10(kf_u10), .kf_z00(kf_z00), .kf_z10(kf_z10),
    .kf_x00_prev(kf_x00_prev), .kf_x10_prev(kf_x10_prev),
    .kf_X00_post(kf_X00_post), .kf_X10_post(kf_X10_post),
    .m_valid(m_valid), .m_x00(m_x00), .m_x10(m_x10),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kf_start) start_cnt++;
    if (m_valid) mv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k = WAIT edge at which done is seen; k = 0 means done never comes.
  task automatic do_frame(input logic [N-1:0] u0, input logic [N-1:0] u1,
                          input logic [N-1:0] z0, input logic [N-1:0] z1,
                          input int k, input logic [N-1:0] p0, input logic [N-1:0] p1,
                          input bit clr_wait, input bit done_launch);
    int s0;
    int m0;
    s0 = start_cnt;
    m0 = mv_cnt;
    chk("idle_ready", s_ready, 1);
    s_valid = 1'b1; s_u00 = u0; s_u10 = u1; s_z00 = z0; s_z10 = z1;
    step();
    s_valid = 1'b0; s_u00 = ~u0; s_u10 = ~u1; s_z00 = ~z0; s_z10 = ~z1;
    chk("launch_start", kf_start, 1);
    chk("launch_ready", s_ready, 0);
    chk("kf_u00", kf_u00, u0);
    chk("kf_u10", kf_u10, u1);
    chk("kf_z00", kf_z00, z0);
    chk("kf_z10", kf_z10, z1);
    chk("xprev00", kf_x00_prev, ex0);
    chk("xprev10", kf_x10_prev, ex1);
    kf_done = done_launch;
    step();
    kf_done = 1'b0;
    chk("wait_start_low", kf_start, 0);
    for (int i = 1; i <= TMO; i++) begin
      if (i == 1) chk("hold_z10", kf_z10, z1);
      if (i == k) begin
        kf_done = 1'b1; kf_X00_post = p0; kf_X10_post = p1;
      end
      clear_state = clr_wait && (i == 3);
      step();
      kf_done = 1'b0; clear_state = 1'b0; kf_X00_post = ~p0; kf_X10_post = ~p1;
      if (i == k) break;
      chk("no_early_mvalid", m_valid, 0);
      if (i == TMO - 1) chk("ready_before_tmo", s_ready, 0);
    end
    if (k == 0) begin
      eterr = 1'b1;
      chk("tmo_ready", s_ready, 1);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_xprev00", kf_x00_prev, ex0);
      chk("tmo_xprev10", kf_x10_prev, ex1);
      chk("tmo_cnt", frame_cnt, ecnt);
      chk("tmo_no_mvalid", mv_cnt - m0, 0);
    end else begin
      ecnt = ecnt + 1'b1;
      ex0 = clr_wait ? XI0 : p0;
      ex1 = clr_wait ? XI1 : p1;
      chk("commit_mvalid", m_valid, 1);
      chk("commit_mx00", m_x00, p0);
      chk("commit_mx10", m_x10, p1);
      chk("commit_cnt", frame_cnt, ecnt);
      chk("commit_xprev00", kf_x00_prev, ex0);
      chk("commit_xprev10", kf_x10_prev, ex1);
      chk("commit_terr", timeout_err, eterr);
      step();
      chk("post_mvalid_low", m_valid, 0);
      chk("post_ready", s_ready, 1);
      chk("mvalid_once", mv_cnt - m0, 1);
    end
    chk("start_once", start_cnt - s0, 1);
  endtask

  initial begin
    int m0;
    ex0 = XI0; ex1 = XI1; ecnt = '0; eterr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", kf_start, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_xprev00", kf_x00_prev, XI0);
    chk("rst_xprev10", kf_x10_prev, XI1);
    chk("rst_mx00", m_x00, 0);
    chk("rst_u00", kf_u00, 0);
    rst_n = 1'b1;
    step();

    do_frame(20'h00011, 20'h00022, 20'h00033, 20'h00044, 31, 20'h00400, 20'hFFC00, 1'b0, 1'b0);
    do_frame(20'h80000, 20'h7FFFF, 20'hFFFFF, 20'h00001, 5, 20'h00777, 20'hF0001, 1'b0, 1'b0);
    do_frame(20'h00100, 20'h00200, 20'h00300, 20'h00400, 0, 20'h0DEAD, 20'h0BEEF, 1'b0, 1'b0);
    do_frame(20'h00101, 20'h00202, 20'h00303, 20'h00404, 10, 20'h12345, 20'hABCDE, 1'b0, 1'b0);
    do_frame(20'h00555, 20'h00666, 20'h00777, 20'h00888, 8, 20'h01000, 20'h00FFF, 1'b1, 1'b0);
    do_frame(20'h00001, 20'h00002, 20'h00003, 20'h00004, 4, 20'h00AAA, 20'h00BBB, 1'b0, 1'b0);

    clear_state = 1'b1;
    step();
    clear_state = 1'b0;
    ex0 = XI0; ex1 = XI1;
    chk("idle_clr_x00", kf_x00_prev, XI0);
    chk("idle_clr_x10", kf_x10_prev, XI1);
    chk("idle_clr_cnt", frame_cnt, ecnt);

    m0 = mv_cnt;
    kf_done = 1'b1; kf_X00_post = 20'h0F0F0; kf_X10_post = 20'h00F0F;
    repeat (3) step();
    kf_done = 1'b0;
    chk("idle_done_ready", s_ready, 1);
    chk("idle_done_no_mvalid", mv_cnt - m0, 0);
    chk("idle_done_cnt", frame_cnt, ecnt);
    do_frame(20'h00009, 20'h00008, 20'h00007, 20'h00006, 6, 20'h03210, 20'h04321, 1'b0, 1'b1);

    for (int f = 0; f < 12; f++)
      do_frame(N'(f), N'(f + 1), N'(f + 2), N'(f + 3), 2, N'(20'h10000 + f), N'(20'h20000 + f),
               1'b0, 1'b0);
    chk("wrap_cnt", frame_cnt, 2);

    s_valid = 1'b1; s_u00 = 20'h0ABCD; s_u10 = 20'h01234; s_z00 = 20'h05678; s_z10 = 20'h09ABC;
    step();
    s_valid = 1'b0;
    step();
    repeat (14) step();
    chk("pre_rst_ready", s_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", s_ready, 1);
    chk("arst_cnt", frame_cnt, 0);
    chk("arst_terr", timeout_err, 0);
    chk("arst_mvalid", m_valid, 0);
    chk("arst_xprev00", kf_x00_prev, XI0);
    chk("arst_xprev10", kf_x10_prev, XI1);
    chk("arst_mx10", m_x10, 0);
    chk("arst_u00", kf_u00, 0);
    m0 = mv_cnt;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    kf_done = 1'b1; kf_X00_post = 20'h07777; kf_X10_post = 20'h08888;
    repeat (3) step();
    kf_done = 1'b0;
    chk("arst_no_mvalid", mv_cnt - m0, 0);
    chk("arst_cnt_after", frame_cnt, 0);
    chk("arst_mx00_after", m_x00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
